// File: rtl/rgmii_tx_ddr_sched.sv
// RGMII transmit sequencer: turns the MAC's GMII byte stream into rising/falling
// edge pairs for the txd, tx_ctl and forwarded-clock output-DDR primitives.
// 1000M passes one byte per cycle; 100M/10M send each byte as two SDR nibbles of
// N cycles each (N=5 / N=50), with a divided forwarded clock and a byte strobe.
module rgmii_tx_ddr_sched (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] speed,
  input  logic [7:0] gmii_txd,
  input  logic       gmii_tx_en,
  input  logic       gmii_tx_er,
  output logic       gmii_clk_en,
  output logic [3:0] txd_d1,
  output logic [3:0] txd_d2,
  output logic       ctl_d1,
  output logic       ctl_d2,
  output logic       clk_d1,
  output logic       clk_d2
);

  // Link state
  logic [1:0] speed_reg, speed_next;
  logic [6:0] cnt_reg, cnt_next;
  logic [7:0] byte_reg, byte_next;
  logic       en_reg, en_next;
  logic       er_reg, er_next;

  // Registered outputs
  logic       stb_reg, stb_next;
  logic [3:0] txd1_reg, txd1_next;
  logic [3:0] txd2_reg, txd2_next;
  logic       ctl1_reg, ctl1_next;
  logic       ctl2_reg, ctl2_next;
  logic       ck1_reg, ck1_next;
  logic       ck2_reg, ck2_next;

  // Helpers for the coming cycle
  logic       boundary;
  logic [6:0] last_next;
  logic [6:0] half_next;
  logic       hi_next;
  logic [6:0] sub_next;
  logic [3:0] nib_next;

  // Last counter value of a byte period (2N-1); speed[1] set means 1000M,
  // where the counter never leaves 0.
  function automatic logic [6:0] last_cnt(input logic [1:0] s);
    return s[0] ? 7'd9 : 7'd99;
  endfunction

  // Byte boundary detection, speed sampling, byte capture and counter advance
  always_comb begin
    boundary   = speed_reg[1] || (cnt_reg >= last_cnt(speed_reg));
    speed_next = boundary ? speed : speed_reg;
    cnt_next   = boundary ? 7'd0 : cnt_reg + 7'd1;
    // The strobe register is high exactly in the cycle the MAC byte is consumed.
    byte_next  = stb_reg ? gmii_txd   : byte_reg;
    en_next    = stb_reg ? gmii_tx_en : en_reg;
    er_next    = stb_reg ? gmii_tx_er : er_reg;
  end

  // Output patterns for the coming cycle, derived from next state so that
  // every output leaves a flop with no input-to-output path
  always_comb begin
    last_next = last_cnt(speed_next);
    half_next = speed_next[0] ? 7'd5 : 7'd50;
    hi_next   = (cnt_next >= half_next);
    sub_next  = hi_next ? (cnt_next - half_next) : cnt_next;
    nib_next  = hi_next ? byte_next[7:4] : byte_next[3:0];
    ctl1_next = en_next;
    ctl2_next = en_next ^ er_next;
    stb_next  = 1'b1;
    txd1_next = byte_next[3:0];
    txd2_next = byte_next[7:4];
    ck1_next  = 1'b1;
    ck2_next  = 1'b0;
    if (!speed_next[1]) begin
      stb_next  = (cnt_next == last_next);
      txd1_next = nib_next;
      txd2_next = nib_next;
      if (speed_next[0]) begin
        // 25 MHz: 2.5 cycles high, 2.5 low, rising at the start of each nibble
        ck1_next = (sub_next <= 7'd2);
        ck2_next = (sub_next <= 7'd1);
      end else begin
        ck1_next = (sub_next < 7'd25);
        ck2_next = (sub_next < 7'd25);
      end
    end
  end

  // State and output registers; reset drops everything to idle and loads speed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      speed_reg <= speed;
      cnt_reg   <= 7'd0;
      byte_reg  <= 8'd0;
      en_reg    <= 1'b0;
      er_reg    <= 1'b0;
      stb_reg   <= 1'b0;
      txd1_reg  <= 4'd0;
      txd2_reg  <= 4'd0;
      ctl1_reg  <= 1'b0;
      ctl2_reg  <= 1'b0;
      ck1_reg   <= 1'b0;
      ck2_reg   <= 1'b0;
    end else begin
      speed_reg <= speed_next;
      cnt_reg   <= cnt_next;
      byte_reg  <= byte_next;
      en_reg    <= en_next;
      er_reg    <= er_next;
      stb_reg   <= stb_next;
      txd1_reg  <= txd1_next;
      txd2_reg  <= txd2_next;
      ctl1_reg  <= ctl1_next;
      ctl2_reg  <= ctl2_next;
      ck1_reg   <= ck1_next;
      ck2_reg   <= ck2_next;
    end
  end

  assign gmii_clk_en = stb_reg;
  assign txd_d1      = txd1_reg;
  assign txd_d2      = txd2_reg;
  assign ctl_d1      = ctl1_reg;
  assign ctl_d2      = ctl2_reg;
  assign clk_d1      = ck1_reg;
  assign clk_d2      = ck2_reg;

endmodule

// File: tb/tb_rgmii_tx_ddr_sched.sv
// Bench for rgmii_tx_ddr_sched. A slot-level model expands each consumed byte
// into the expected per-cycle output records; directed checks add the literal
// values from the test plan.
module tb_rgmii_tx_ddr_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] speed = 2'b10;
  logic [7:0] gmii_txd = 8'h00;
  logic       gmii_tx_en = 1'b0;
  logic       gmii_tx_er = 1'b0;
  logic       gmii_clk_en;
  logic [3:0] txd_d1, txd_d2;
  logic       ctl_d1, ctl_d2, clk_d1, clk_d2;
  logic [12:0] obs;

  int checks = 0;
  int errors = 0;

  // Expected output records {strobe, txd_d1, txd_d2, ctl_d1, ctl_d2, clk_d1, clk_d2}
  logic [12:0] q[$];

  always #4 clk = ~clk;

  assign obs = {gmii_clk_en, txd_d1, txd_d2, ctl_d1, ctl_d2, clk_d1, clk_d2};

  rgmii_tx_ddr_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .speed       (speed),
    .gmii_txd    (gmii_txd),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_tx_er  (gmii_tx_er),
    .gmii_clk_en (gmii_clk_en),
    .txd_d1      (txd_d1),
    .txd_d2      (txd_d2),
    .ctl_d1      (ctl_d1),
    .ctl_d2      (ctl_d2),
    .clk_d1      (clk_d1),
    .clk_d2      (clk_d2)
  );

  // One byte slot: 1 cycle at 1000M, otherwise 2N cycles of nibbles with a
  // 50%-duty forwarded clock of period N; strobe on the slot's last cycle.
  task automatic push_slot(input logic [1:0] s, input logic [7:0] b,
                           input logic en, input logic er, input int first);
    int n;
    if (s[1]) begin
      q.push_back({1'b1, b[3:0], b[7:4], en, en ^ er, 1'b1, 1'b0});
    end else begin
      n = s[0] ? 5 : 50;
      for (int i = first; i < 2 * n; i++) begin
        int p;
        logic [3:0] nib;
        logic stb, r_hi, f_hi;
        p    = i % n;
        nib  = (i < n) ? b[3:0] : b[7:4];
        stb  = (i == 2 * n - 1);
        r_hi = (2 * p < n);
        f_hi = (2 * p + 1 < n);
        q.push_back({stb, nib, nib, en, en ^ er, r_hi, f_hi});
      end
    end
  endtask

  // Pops this cycle's expectation, then extends the model with what the
  // upcoming edge does (reset, or consumption of the current MAC byte).
  task automatic model_step(output logic [12:0] e);
    e = (q.size() > 0) ? q.pop_front() : 13'h0;
    if (!rst_n) begin
      q.delete();
      q.push_back(13'h0);
      push_slot(speed, 8'h00, 1'b0, 1'b0, speed[1] ? 0 : 1);
    end else if (e[12]) begin
      push_slot(speed, gmii_txd, gmii_tx_en, gmii_tx_er, 0);
    end
  endtask

  // Advance to the next falling edge, apply this cycle's inputs, get expectation
  task automatic step(input logic r, input logic [1:0] s, input logic [7:0] d,
                      input logic en, input logic er, output logic [12:0] e);
    @(negedge clk);
    rst_n      = r;
    speed      = s;
    gmii_txd   = d;
    gmii_tx_en = en;
    gmii_tx_er = er;
    model_step(e);
  endtask

  task automatic test_reset();
    logic [12:0] e;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 2'b10, 8'hFF, 1'b1, 1'b0, e);
      checks++;
      if (obs !== 13'h0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%h want=%h", i, obs, 13'h0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, e);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_release cyc=%0d got=%h want=%h", i, obs, e);
      end
      if (i == 1) begin
        checks++;
        if (gmii_clk_en !== 1'b1) begin
          errors++;
          $display("FAIL reset_first_strobe_1000m got=%b want=1", gmii_clk_en);
        end
      end
    end
  endtask

  task automatic test_gig_stream();
    logic [12:0] e;
    logic [7:0] arr [3];
    logic [7:0] b;
    arr = '{8'h55, 8'hD5, 8'hA5};
    for (int i = 0; i < 36; i++) begin
      if (i < 3) step(1'b1, 2'b10, arr[i], 1'b1, 1'b0, e);
      else step(1'b1, 2'b10, 8'($urandom), ($urandom_range(0, 4) != 0), ($urandom_range(0, 5) == 0), e);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL gig_model cyc=%0d got=%h want=%h", i, obs, e);
      end
      if (i >= 1 && i <= 3) begin
        b = arr[i - 1];
        checks++;
        if ({txd_d1, txd_d2, ctl_d1, ctl_d2, clk_d1, clk_d2} !== {b[3:0], b[7:4], 4'b1110}) begin
          errors++;
          $display("FAIL gig_bytes cyc=%0d got=%h/%h ctl=%b%b clk=%b%b want=%h/%h ctl=11 clk=10",
                   i, txd_d1, txd_d2, ctl_d1, ctl_d2, clk_d1, clk_d2, b[3:0], b[7:4]);
        end
      end
    end
  endtask

  task automatic test_100m();
    logic [12:0] e;
    logic [1:0] pat [5];
    logic [7:0] b;
    int ph;
    pat = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b00};
    b = 8'hA5;
    step(1'b1, 2'b01, b, 1'b1, 1'b0, e);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL m100_switch got=%h want=%h", obs, e);
    end
    ph = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 2'b01, b, 1'b1, 1'b0, e);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL m100_model cyc=%0d got=%h want=%h", i, obs, e);
      end
      checks++;
      if ({txd_d1, txd_d2} !== ((ph < 5) ? {b[3:0], b[3:0]} : {b[7:4], b[7:4]})) begin
        errors++;
        $display("FAIL m100_nibble ph=%0d got=%h/%h", ph, txd_d1, txd_d2);
      end
      checks++;
      if ({clk_d1, clk_d2} !== pat[ph % 5]) begin
        errors++;
        $display("FAIL m100_clock ph=%0d got=%b%b want=%b", ph, clk_d1, clk_d2, pat[ph % 5]);
      end
      checks++;
      if (gmii_clk_en !== (ph == 9)) begin
        errors++;
        $display("FAIL m100_strobe ph=%0d got=%b want=%b", ph, gmii_clk_en, (ph == 9));
      end
      ph = (ph + 1) % 10;
    end
  endtask

  task automatic test_10m_err();
    logic [12:0] e;
    logic found, hi;
    int ph;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 2'b00, 8'($urandom), 1'b1, 1'b1, e);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL m10_sync_model cyc=%0d got=%h want=%h", i, obs, e);
      end
      found = gmii_clk_en;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL m10_sync got=no_strobe want=strobe_within_20");
    end
    ph = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 2'b00, 8'($urandom), 1'b1, 1'b1, e);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL m10_model cyc=%0d got=%h want=%h", i, obs, e);
      end
      hi = ((ph % 50) < 25);
      checks++;
      if ({ctl_d1, ctl_d2, clk_d1, clk_d2, gmii_clk_en} !== {1'b1, 1'b0, hi, hi, (ph == 99)}) begin
        errors++;
        $display("FAIL m10_ctl_clk_strobe ph=%0d got=%b%b/%b%b/%b want=10/%b%b/%b",
                 ph, ctl_d1, ctl_d2, clk_d1, clk_d2, gmii_clk_en, hi, hi, (ph == 99));
      end
      ph = (ph + 1) % 100;
    end
  endtask

  task automatic test_speed_change();
    logic [12:0] e;
    logic [1:0] pat [5];
    logic [1:0] s;
    logic [7:0] b, d;
    logic found;
    pat = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b00};
    b = 8'h3C;
    found = 1'b0;
    for (int i = 0; i < 120 && !found; i++) begin
      step(1'b1, 2'b01, b, 1'b1, 1'b0, e);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL chg_sync_model cyc=%0d got=%h want=%h", i, obs, e);
      end
      found = gmii_clk_en;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL chg_sync got=no_strobe want=strobe_within_120");
    end
    for (int ph = 0; ph < 14; ph++) begin
      s = (ph >= 3) ? 2'b10 : 2'b01;
      d = (ph == 9) ? 8'h96 : 8'($urandom);
      step(1'b1, s, d, 1'b1, 1'b0, e);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL chg_model ph=%0d got=%h want=%h", ph, obs, e);
      end
      if (ph <= 9) begin
        checks++;
        if ({txd_d1, txd_d2, clk_d1, clk_d2, gmii_clk_en} !==
            {((ph < 5) ? {b[3:0], b[3:0]} : {b[7:4], b[7:4]}), pat[ph % 5], (ph == 9)}) begin
          errors++;
          $display("FAIL chg_byte_completes ph=%0d got=%h/%h clk=%b%b stb=%b", ph, txd_d1, txd_d2,
                   clk_d1, clk_d2, gmii_clk_en);
        end
      end else if (ph == 10) begin
        checks++;
        if ({txd_d1, txd_d2, clk_d1, clk_d2, gmii_clk_en} !== {4'h6, 4'h9, 2'b10, 1'b1}) begin
          errors++;
          $display("FAIL chg_gig_start got=%h/%h clk=%b%b stb=%b want=6/9 clk=10 stb=1",
                   txd_d1, txd_d2, clk_d1, clk_d2, gmii_clk_en);
        end
      end
    end
  endtask

  task automatic test_reset_mid_10m();
    logic [12:0] e;
    logic found;
    found = 1'b0;
    for (int i = 0; i < 120 && !found; i++) begin
      step(1'b1, 2'b00, 8'($urandom), 1'b1, 1'b0, e);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rmid_sync_model cyc=%0d got=%h want=%h", i, obs, e);
      end
      found = gmii_clk_en;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rmid_sync got=no_strobe want=strobe_within_120");
    end
    for (int ph = 0; ph <= 37; ph++) begin
      step((ph != 37), 2'b00, 8'($urandom), 1'b1, 1'b0, e);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rmid_model ph=%0d got=%h want=%h", ph, obs, e);
      end
    end
    step(1'b0, 2'b00, 8'hFF, 1'b1, 1'b0, e);
    checks++;
    if (obs !== 13'h0) begin
      errors++;
      $display("FAIL rmid_abort got=%h want=%h", obs, 13'h0);
    end
    for (int k = 0; k < 120; k++) begin
      step(1'b1, 2'b00, 8'($urandom), 1'b1, 1'b0, e);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rmid_release_model k=%0d got=%h want=%h", k, obs, e);
      end
      checks++;
      if (gmii_clk_en !== (k == 99)) begin
        errors++;
        $display("FAIL rmid_first_strobe k=%0d got=%b want=%b", k, gmii_clk_en, (k == 99));
      end
    end
  endtask

  task automatic test_random();
    logic [12:0] e;
    logic [1:0] s;
    logic r;
    int rh, cool;
    s = 2'b00;
    rh = 0;
    cool = 0;
    for (int i = 0; i < 1500; i++) begin
      r = 1'b1;
      if (rh > 0) begin
        r = 1'b0;
        rh--;
        cool = 2;
      end else if ($urandom_range(0, 399) == 0) begin
        r = 1'b0;
        rh = $urandom_range(0, 2);
        cool = 2;
      end else if (cool > 0) begin
        cool--;
      end else if ($urandom_range(0, 59) == 0) begin
        s = 2'($urandom_range(0, 3));
      end
      step(r, s, 8'($urandom), ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) == 0), e);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL random_model cyc=%0d spd=%b got=%h want=%h", i, s, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_gig_stream();
    test_100m();
    test_10m_err();
    test_speed_change();
    test_reset_mid_10m();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
